// File: rtl/adc_mux_responder_pkg.sv
// Shared constants and state encoding for the ADC/mux serial responder.
package adc_mux_responder_pkg;

   localparam int CMD_BITS_DEF    = 8;
   localparam int CH_POS_DEF      = 4;
   localparam int SYNC_STAGES_DEF = 2;
   localparam int ADC_DATA_W      = 12;
   localparam int FRAME_BITS      = 16;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_CMD_SHIFT   = 2'd1,
      ST_SAMPLE_WAIT = 2'd2,
      ST_DATA_SHIFT  = 2'd3
   } state_t;

endpackage

// File: rtl/adc_mux_responder_if.sv
// Local sample fetch handshake: responder requests a channel, the source acks with data for one cycle.
interface adc_mux_responder_if;
   import adc_mux_responder_pkg::*;

   logic                  sample_req;
   logic [2:0]            sample_ch;
   logic                  sample_ack;
   logic [ADC_DATA_W-1:0] sample_data;

   modport master (output sample_req, sample_ch, input sample_ack, sample_data);
   modport slave  (input sample_req, sample_ch, output sample_ack, sample_data);

endinterface

// File: rtl/adc_mux_responder_sync_edge_det.sv
// N-stage synchronizer with single-cycle rise/fall strobes; strobes lag the pin by STAGES clk.
// No backpressure: strobes are fire-and-forget.
module adc_mux_responder_sync_edge_det #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_l,
   input  logic din,
   output logic lvl,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q[0] <= din;
         for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign lvl  = sync_q[STAGES-1];
   assign rise = lvl & ~prev_q;
   assign fall = ~lvl & prev_q;

endmodule

// File: rtl/adc_mux_responder.sv
// Device end of the ADC + mux serial link: decode channel command, fetch sample, shift it out on DOUT.
// cd_fall->sample_req and sclk_rise->DOUT both take SYNC_STAGES+1 clk; a late sample_ack flags underrun.
module adc_mux_responder
   import adc_mux_responder_pkg::*;
#(
   parameter int CMD_BITS    = CMD_BITS_DEF,
   parameter int CH_POS      = CH_POS_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic                clk,
   input  logic                rst_l,
   input  logic                SCLK,
   input  logic                CS_ADC,
   input  logic                CD_MUX,
   input  logic                DIN,
   output logic                DOUT,
   adc_mux_responder_if.master smp,
   output logic                cmd_valid,
   output logic [2:0]          cmd_ch,
   output logic                busy,
   output logic                underrun,
   input  logic                clr_err
);

   localparam int CNT_W = $clog2(((CMD_BITS > FRAME_BITS) ? CMD_BITS : FRAME_BITS) + 1);
   localparam logic [CNT_W-1:0] CMD_CNT   = CNT_W'(CMD_BITS);
   localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic cd_lvl, cd_rise, cd_fall;
   logic din_lvl, din_rise, din_fall;

   adc_mux_responder_sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .rst_l(rst_l), .din(SCLK), .lvl(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
   adc_mux_responder_sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_cs (
      .clk(clk), .rst_l(rst_l), .din(CS_ADC), .lvl(cs_lvl), .rise(cs_rise), .fall(cs_fall));
   adc_mux_responder_sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_cd (
      .clk(clk), .rst_l(rst_l), .din(CD_MUX), .lvl(cd_lvl), .rise(cd_rise), .fall(cd_fall));
   adc_mux_responder_sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_din (
      .clk(clk), .rst_l(rst_l), .din(DIN), .lvl(din_lvl), .rise(din_rise), .fall(din_fall));

   state_t                state;
   logic [CMD_BITS-1:0]   cmd_sr;
   logic [FRAME_BITS-1:0] out_sr;
   logic [CNT_W-1:0]      bit_cnt;

   logic unused_sig;
   assign unused_sig = ^{sclk_lvl, cs_rise, cs_fall, cd_lvl, din_rise, din_fall, cmd_sr[CMD_BITS-1]};

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state          <= ST_IDLE;
         cmd_sr         <= '0;
         out_sr         <= '0;
         bit_cnt        <= '0;
         DOUT           <= 1'b0;
         smp.sample_req <= 1'b0;
         smp.sample_ch  <= '0;
         cmd_valid      <= 1'b0;
         cmd_ch         <= '0;
         underrun       <= 1'b0;
      end else begin
         cmd_valid <= 1'b0;
         if (clr_err) underrun <= 1'b0;

         // A new command phase overrides whatever frame was in flight.
         if (cd_rise && (state != ST_IDLE)) begin
            state          <= ST_CMD_SHIFT;
            cmd_sr         <= '0;
            bit_cnt        <= '0;
            out_sr         <= '0;
            DOUT           <= 1'b0;
            smp.sample_req <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (cd_rise && cs_lvl) begin
                     state   <= ST_CMD_SHIFT;
                     cmd_sr  <= '0;
                     bit_cnt <= '0;
                  end
               end
               ST_CMD_SHIFT: begin
                  if (!cs_lvl) begin
                     state <= ST_IDLE;
                  end else if (cd_fall) begin
                     if (bit_cnt == CMD_CNT) begin
                        cmd_ch         <= cmd_sr[CH_POS+2:CH_POS];
                        smp.sample_ch  <= cmd_sr[CH_POS+2:CH_POS];
                        cmd_valid      <= 1'b1;
                        smp.sample_req <= 1'b1;
                        state          <= ST_SAMPLE_WAIT;
                     end else begin
                        state <= ST_IDLE;
                     end
                  end else if (sclk_rise) begin
                     cmd_sr <= {cmd_sr[CMD_BITS-2:0], din_lvl};
                     if (bit_cnt != CMD_CNT) bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               ST_SAMPLE_WAIT: begin
                  // Ack beats a coincident dummy edge; a pending request at the dummy edge is an underrun.
                  if (smp.sample_req && smp.sample_ack) begin
                     out_sr         <= {{(FRAME_BITS-ADC_DATA_W){1'b0}}, smp.sample_data};
                     smp.sample_req <= 1'b0;
                     if (sclk_rise) begin
                        state   <= ST_DATA_SHIFT;
                        bit_cnt <= '0;
                     end
                  end else if (sclk_rise) begin
                     if (smp.sample_req) begin
                        underrun       <= 1'b1;
                        out_sr         <= '0;
                        smp.sample_req <= 1'b0;
                     end
                     state   <= ST_DATA_SHIFT;
                     bit_cnt <= '0;
                  end
               end
               ST_DATA_SHIFT: begin
                  if (sclk_rise && (bit_cnt != FRAME_CNT)) begin
                     DOUT    <= out_sr[FRAME_BITS-1];
                     out_sr  <= {out_sr[FRAME_BITS-2:0], 1'b0};
                     bit_cnt <= bit_cnt + 1'b1;
                  end else if (sclk_fall && (bit_cnt == FRAME_CNT)) begin
                     DOUT  <= 1'b0;
                     state <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adc_mux_responder.sv
// Bench for adc_mux_responder: acts as acquisition master and sample source, checks frames against a model.
module tb_adc_mux_responder;
   import adc_mux_responder_pkg::*;

   localparam int HALF = 8;
   localparam int GAP  = 16;
   localparam int LAT  = SYNC_STAGES_DEF + 1;

   logic       clk, rst_l, SCLK, CS_ADC, CD_MUX, DIN, DOUT;
   logic       cmd_valid, busy, underrun, clr_err;
   logic [2:0] cmd_ch;

   adc_mux_responder_if ifc();

   adc_mux_responder dut (
      .clk(clk), .rst_l(rst_l), .SCLK(SCLK), .CS_ADC(CS_ADC), .CD_MUX(CD_MUX), .DIN(DIN),
      .DOUT(DOUT), .smp(ifc), .cmd_valid(cmd_valid), .cmd_ch(cmd_ch), .busy(busy),
      .underrun(underrun), .clr_err(clr_err));

   int          n_checks = 0;
   int          n_errors = 0;
   int          cv_cnt   = 0;
   int          req_cnt  = 0;
   logic        req_prev = 1'b0;
   bit          ack_en   = 1'b1;
   int          ack_dly  = 1;
   int          req_age  = 0;
   logic [11:0] src_mem [8];

   typedef struct {
      logic [7:0]  cmd;
      int          ncmd;
      bit          aen;
      int          dly;
      logic [11:0] data;
      logic [15:0] exp_cap;
      bit          exp_cmd;
      bit          exp_unr;
   } vec_t;
   vec_t vecs [11];

   logic [15:0] cap, m_cap;
   int          lat, r_ncmd, r_dly;
   logic [7:0]  r_cmd;
   logic [2:0]  m_ch, r_ch;
   bit          m_unr, r_aen, well;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal;
   end

   always @(negedge clk) begin
      if (cmd_valid) cv_cnt++;
      if (ifc.sample_req && !req_prev) req_cnt++;
      req_prev = ifc.sample_req;
   end

   // Sample source: acks ack_dly cycles after seeing a request, or never when ack_en is clear.
   initial begin
      ifc.sample_ack  = 1'b0;
      ifc.sample_data = '0;
      forever begin
         @(negedge clk);
         ifc.sample_ack = 1'b0;
         if (ifc.sample_req) begin
            req_age++;
            if (ack_en && req_age >= ack_dly) begin
               ifc.sample_ack  = 1'b1;
               ifc.sample_data = src_mem[ifc.sample_ch];
            end
         end else begin
            req_age = 0;
         end
      end
   end

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      clks(1);
      clr_err = 1'b0;
      clks(1);
   endtask

   // One master frame: ncmd command bits MSB first, then ndata SCLK cycles (first is the dummy).
   task automatic run_frame(input logic [7:0] cmd, input int ncmd, input int ndata,
                            input bit clr_at_dummy, output logic [15:0] fcap, output int flat);
      fcap   = '0;
      flat   = -1;
      CD_MUX = 1'b1;
      clks(4);
      for (int i = 0; i < ncmd; i++) begin
         DIN = cmd[7-i];
         clks(HALF);
         SCLK = 1'b1;
         clks(HALF);
         SCLK = 1'b0;
      end
      clks(HALF);
      CD_MUX = 1'b0;
      for (int i = 1; i <= GAP; i++) begin
         clks(1);
         if (flat < 0 && ifc.sample_req) flat = i;
      end
      for (int k = 0; k < ndata; k++) begin
         SCLK = 1'b1;
         if (clr_at_dummy && k == 0) begin
            clks(LAT - 1);
            clr_err = 1'b1;
            clks(1);
            clr_err = 1'b0;
            clks(HALF - LAT);
         end else begin
            clks(HALF);
         end
         if (k > 0) fcap = {fcap[14:0], DOUT};
         SCLK = 1'b0;
         clks(HALF);
      end
      clks(6);
   endtask

   task automatic frame_check(input string tag, input logic [7:0] cmd, input int ncmd, input bit aen,
                              input int dly, input logic [15:0] exp_cap, input bit exp_cmd,
                              input bit exp_unr, input logic [2:0] exp_ch);
      logic [15:0] fcap;
      int          flat, cv0, rq0;
      ack_en  = aen;
      ack_dly = dly;
      cv0     = cv_cnt;
      rq0     = req_cnt;
      run_frame(cmd, ncmd, 17, 1'b0, fcap, flat);
      check({tag, " capture"}, fcap, exp_cap);
      check({tag, " cmd_valid count"}, cv_cnt - cv0, exp_cmd);
      check({tag, " sample_req count"}, req_cnt - rq0, exp_cmd);
      check({tag, " cmd_ch"}, cmd_ch, exp_ch);
      check({tag, " sample_ch"}, ifc.sample_ch, exp_ch);
      check({tag, " underrun"}, underrun, exp_unr);
      check({tag, " idle busy/dout"}, {busy, DOUT}, 2'b00);
      if (exp_cmd) check({tag, " req latency"}, flat, LAT);
   endtask

   initial begin
      rst_l = 1'b0; SCLK = 1'b0; CS_ADC = 1'b1; CD_MUX = 1'b0; DIN = 1'b0; clr_err = 1'b0;
      for (int c = 0; c < 8; c++) src_mem[c] = '0;
      clks(3);
      check("reset outputs", {DOUT, busy, cmd_valid, cmd_ch, underrun, ifc.sample_req, ifc.sample_ch}, 0);
      rst_l = 1'b1;
      clks(4);

      vecs[0] = '{8'h30, 8, 1'b1, 2, 12'hA5C, 16'h0A5C, 1'b1, 1'b0};
      for (int c = 0; c < 8; c++)
         vecs[1+c] = '{8'h85 | 8'(c << 4), 8, 1'b1, 1, 12'h100 + 12'(c), 16'h0100 + 16'(c), 1'b1, 1'b0};
      vecs[9]  = '{8'h60, 8, 1'b0, 1, 12'h777, 16'h0000, 1'b1, 1'b1};
      vecs[10] = '{8'h70, 5, 1'b1, 1, 12'h123, 16'h0000, 1'b0, 1'b1};

      m_ch = 3'd0;
      for (int i = 0; i < 11; i++) begin
         src_mem[vecs[i].cmd[6:4]] = vecs[i].data;
         if (vecs[i].exp_cmd) m_ch = vecs[i].cmd[6:4];
         frame_check($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].ncmd, vecs[i].aen, vecs[i].dly,
                     vecs[i].exp_cap, vecs[i].exp_cmd, vecs[i].exp_unr, m_ch);
      end

      pulse_clr();
      check("clr_err clears underrun", underrun, 1'b0);

      // Clear and a fresh underrun land in the same cycle: the set must win.
      ack_en = 1'b0;
      run_frame(8'h10, 8, 17, 1'b1, cap, lat);
      m_ch = 3'd1;
      check("underrun beats same-cycle clr", underrun, 1'b1);
      check("underrun capture", cap, 16'h0000);
      pulse_clr();
      check("underrun cleared again", underrun, 1'b0);

      // Abort while the request is still pending.
      run_frame(8'h40, 8, 0, 1'b0, cap, lat);
      m_ch = 3'd4;
      check("pending req before abort", ifc.sample_req, 1'b1);
      CD_MUX = 1'b1;
      clks(LAT + 1);
      check("abort drops sample_req", ifc.sample_req, 1'b0);
      check("abort in cmd shift busy", busy, 1'b1);
      CD_MUX = 1'b0;
      clks(8);
      check("empty command returns idle", busy, 1'b0);

      // Abort after 7 data bits, then a clean channel 5 frame.
      ack_en = 1'b1; ack_dly = 2; src_mem[2] = 12'h2BD;
      run_frame(8'h20, 8, 8, 1'b0, cap, lat);
      check("partial capture", cap, 16'h0001);
      check("mid-data busy", busy, 1'b1);
      src_mem[5] = 12'h5A5;
      m_ch = 3'd5;
      frame_check("after abort", 8'h50, 8, 1'b1, 3, 16'h05A5, 1'b1, 1'b0, 3'd5);

      CD_MUX = 1'b1;
      clks(6);
      check("cmd phase busy", busy, 1'b1);
      CS_ADC = 1'b0;
      clks(6);
      check("cs low leaves cmd shift", busy, 1'b0);
      CD_MUX = 1'b0;
      CS_ADC = 1'b1;
      clks(6);
      check("cs restore stays idle", {busy, ifc.sample_req}, 2'b00);

      // Reset in the middle of the data phase.
      src_mem[6] = 12'hFFF; ack_en = 1'b1; ack_dly = 1;
      run_frame(8'hE0, 8, 9, 1'b0, cap, lat);
      check("pre-reset busy/dout", {busy, DOUT}, 2'b11);
      rst_l = 1'b0;
      #1;
      check("async reset outputs", {DOUT, busy, cmd_valid, cmd_ch, underrun, ifc.sample_req, ifc.sample_ch}, 0);
      clks(2);
      rst_l = 1'b1;
      clks(2);
      src_mem[7] = 12'h3C9;
      m_ch = 3'd7;
      m_unr = 1'b0;
      frame_check("post reset", 8'h70, 8, 1'b1, 2, 16'h03C9, 1'b1, 1'b0, 3'd7);

      for (int r = 0; r < 20; r++) begin
         r_cmd  = 8'($urandom);
         r_ncmd = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 8;
         r_aen  = ($urandom_range(0, 3) != 0);
         r_dly  = int'($urandom_range(1, 6));
         if ($urandom_range(0, 1) == 1) begin
            pulse_clr();
            m_unr = 1'b0;
         end
         r_ch = 3'((r_cmd >> CH_POS_DEF) & 8'h07);
         src_mem[r_ch] = 12'($urandom);
         well = (r_ncmd == CMD_BITS_DEF);
         if (well) begin
            m_ch = r_ch;
            if (!r_aen) m_unr = 1'b1;
         end
         m_cap = (well && r_aen) ? {4'h0, src_mem[r_ch]} : 16'h0000;
         frame_check($sformatf("rand%0d", r), r_cmd, r_ncmd, r_aen, r_dly, m_cap, well, m_unr, m_ch);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
